// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX pipeline status in, pipeline control out.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      id_instru;
  logic             ex_MemRead;
  logic [4:0]       ex_Rd;
  logic             ex_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_flush;
  logic             ID_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_instru, ex_MemRead, ex_Rd, ex_taken, mem_busy,
    input  pc_write, IF_ID_write, IF_flush, ID_flush, pipe_hold,
           stall_count, flush_count
  );

  modport slave (
    input  id_instru, ex_MemRead, ex_Rd, ex_taken, mem_busy,
    output pc_write, IF_ID_write, IF_flush, ID_flush, pipe_hold,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV64 pipeline: load-use stalls, branch
// flushes and memory-busy freezes. STALL_CYCLES (1..3) sets the load-use
// bubble length. Define HAZARD_PERF_EN to build the stall/flush performance
// counters; otherwise both count ports are tied to zero.
module hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic        clock,
  input  logic        reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, STALL} state_e;

  state_e     state_q, state_d;
  logic [1:0] rem_q, rem_d;

  // Operand usage decode of the instruction sitting in ID.
  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2, lu_hit;

  assign opcode   = hz.id_instru[6:0];
  assign rs1      = hz.id_instru[19:15];
  assign rs2      = hz.id_instru[24:20];
  assign uses_rs1 = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign uses_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign lu_hit   = hz.ex_MemRead && (hz.ex_Rd != 5'd0) &&
                    ((uses_rs1 && hz.ex_Rd == rs1) || (uses_rs2 && hz.ex_Rd == rs2));

  // Remaining instruction fields only matter to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{hz.id_instru[31:25], hz.id_instru[14:7]};

  logic pc_write, if_id_write, if_flush, id_flush, pipe_hold;

  // Next-state and control outputs, in priority order reset > busy > taken > stall.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    pipe_hold   = 1'b0;
    state_d     = state_q;
    rem_d       = rem_q;

    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      state_d     = RUN;
      rem_d       = 2'd0;
    end else if (hz.mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (hz.ex_taken) begin
      // The dependent instruction is killed, so a pending stall is dropped.
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      state_d     = RUN;
      rem_d       = 2'd0;
    end else if (state_q == STALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_flush    = 1'b1;
      if (rem_q <= 2'd1) begin
        state_d = RUN;
        rem_d   = 2'd0;
      end else begin
        rem_d   = rem_q - 2'd1;
      end
    end else if (lu_hit) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_flush    = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_d = STALL;
        rem_d   = 2'(STALL_CYCLES - 1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.IF_ID_write = if_id_write;
  assign hz.IF_flush    = if_flush;
  assign hz.ID_flush    = id_flush;
  assign hz.pipe_hold   = pipe_hold;

`ifdef HAZARD_PERF_EN
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  assign stall_inc = !reset && !hz.mem_busy && !hz.ex_taken && (state_q == STALL || lu_hit);
  assign flush_inc = !reset && !hz.mem_busy && hz.ex_taken;

  // Wrapping performance counters; frozen while memory is busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
`else
  assign hz.stall_count = {CNT_W{1'b0}};
  assign hz.flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances (STALL_CYCLES 1..3)
// share one stimulus stream and are compared every cycle against a
// bubble-countdown reference model; directed cases pin the model.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] id_instru;
  logic        ex_MemRead;
  logic [4:0]  ex_Rd;
  logic        ex_taken;
  logic        mem_busy;

  // {pc_write, IF_ID_write, IF_flush, ID_flush, pipe_hold} per instance.
  logic [4:0]       flags_o [3];
  logic [CNT_W-1:0] scnt_o  [3];
  logic [CNT_W-1:0] fcnt_o  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
    assign hif.id_instru  = id_instru;
    assign hif.ex_MemRead = ex_MemRead;
    assign hif.ex_Rd      = ex_Rd;
    assign hif.ex_taken   = ex_taken;
    assign hif.mem_busy   = mem_busy;

    hazard_ctrl #(.STALL_CYCLES(g + 1), .CNT_W(CNT_W)) u_dut (
      .clock (clock),
      .reset (reset),
      .hz    (hif.slave)
    );

    assign flags_o[g] = {hif.pc_write, hif.IF_ID_write, hif.IF_flush, hif.ID_flush, hif.pipe_hold};
    assign scnt_o[g]  = hif.stall_count;
    assign fcnt_o[g]  = hif.flush_count;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  // Reference model: does the instruction in ID read the register a load in EX writes?
  function automatic bit model_lu(input logic [31:0] ins, input logic mr, input logic [4:0] rd);
    logic [6:0] op;
    bit reads1, reads2;
    op     = ins[6:0];
    reads1 = !(op inside {7'h37, 7'h17, 7'h6F});
    reads2 = op inside {7'h33, 7'h23, 7'h63};
    if (!mr || rd == 5'd0) return 1'b0;
    return (reads1 && ins[19:15] == rd) || (reads2 && ins[24:20] == rd);
  endfunction

  // Model state: bubbles still owed after the current cycle, and event tallies.
  int bubbles_left [3] = '{0, 0, 0};
  int n_stall      [3] = '{0, 0, 0};
  int n_flush      [3] = '{0, 0, 0};

  // Compare every instance against the model, then advance the model.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      logic [4:0] exp;
      check($sformatf("stall_count[sc=%0d]", i + 1), 64'(scnt_o[i]), cnt_exp(n_stall[i]));
      check($sformatf("flush_count[sc=%0d]", i + 1), 64'(fcnt_o[i]), cnt_exp(n_flush[i]));
      if (reset) begin
        exp = 5'b00110;
        bubbles_left[i] = 0;
        n_stall[i] = 0;
        n_flush[i] = 0;
      end else if (mem_busy) begin
        exp = 5'b00001;
      end else if (ex_taken) begin
        exp = 5'b11110;
        bubbles_left[i] = 0;
        n_flush[i]++;
      end else if (bubbles_left[i] > 0) begin
        exp = 5'b00010;
        bubbles_left[i]--;
        n_stall[i]++;
      end else if (model_lu(id_instru, ex_MemRead, ex_Rd)) begin
        exp = 5'b00010;
        bubbles_left[i] = i;
        n_stall[i]++;
      end else begin
        exp = 5'b11000;
      end
      check($sformatf("flags[sc=%0d]", i + 1), 64'(flags_o[i]), 64'(exp));
    end
  end

  task automatic apply(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [31:0] ins, input logic tk, input logic busy);
    @(posedge clock);
    #1;
    reset      = rst;
    ex_MemRead = mr;
    ex_Rd      = rd;
    id_instru  = ins;
    ex_taken   = tk;
    mem_busy   = busy;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 32'h0000_0013, 0, 0);
    apply(1, 0, 0, 32'h0000_0013, 0, 0);
  endtask

  localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;
  localparam logic [31:0] ADDI_X1_X0   = 32'h0010_0093;
  localparam logic [31:0] LUI_X5       = 32'h0002_82B7;
  localparam logic [31:0] SW_X5_X2     = 32'h0051_2023;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  initial begin
    reset = 1'b1; ex_MemRead = 1'b0; ex_Rd = 5'd0; id_instru = NOP;
    ex_taken = 1'b0; mem_busy = 1'b0;

    // Reset outputs.
    sample();
    check("reset_flags", 64'(flags_o[0]), 64'b00110);

    // Single-cycle load-use stall, then normal.
    apply(0, 1, 5, ADD_X6_X5_X7, 0, 0); sample();
    check("lu_flags", 64'(flags_o[0]), 64'b00010);
    apply(0, 0, 5, ADD_X6_X5_X7, 0, 0); sample();
    check("lu_after", 64'(flags_o[0]), 64'b11000);
    check("lu_stall_count", 64'(scnt_o[0]), cnt_exp(1));

    // No false stalls; store rs2 dependency does stall.
    do_reset();
    apply(0, 1, 0, ADDI_X1_X0, 0, 0); sample();
    check("rd0_no_stall", 64'(flags_o[0]), 64'b11000);
    apply(0, 1, 5, LUI_X5, 0, 0); sample();
    check("lui_no_stall", 64'(flags_o[0]), 64'b11000);
    apply(0, 1, 5, SW_X5_X2, 0, 0); sample();
    check("store_rs2_stall", 64'(flags_o[0]), 64'b00010);

    // Branch beats load-use.
    do_reset();
    apply(0, 1, 5, ADD_X6_X5_X7, 1, 0); sample();
    check("taken_flags", 64'(flags_o[0]), 64'b11110);
    apply(0, 0, 0, NOP, 0, 0); sample();
    check("taken_flush_count", 64'(fcnt_o[0]), cnt_exp(1));
    check("taken_stall_count", 64'(scnt_o[0]), cnt_exp(0));

    // STALL_CYCLES=2: two bubble cycles.
    do_reset();
    apply(0, 1, 5, ADD_X6_X5_X7, 0, 0); sample();
    check("sc2_cyc1", 64'(flags_o[1]), 64'b00010);
    apply(0, 0, 0, NOP, 0, 0); sample();
    check("sc2_cyc2", 64'(flags_o[1]), 64'b00010);
    apply(0, 0, 0, NOP, 0, 0); sample();
    check("sc2_done", 64'(flags_o[1]), 64'b11000);
    check("sc2_stall_count", 64'(scnt_o[1]), cnt_exp(2));

    // STALL_CYCLES=2 with a branch in the second bubble cycle.
    do_reset();
    apply(0, 1, 5, ADD_X6_X5_X7, 0, 0); sample();
    apply(0, 0, 0, NOP, 1, 0); sample();
    check("sc2_taken", 64'(flags_o[1]), 64'b11110);
    apply(0, 0, 0, NOP, 0, 0); sample();
    check("sc2_taken_run", 64'(flags_o[1]), 64'b11000);

    // mem_busy freezes a stall mid-way.
    do_reset();
    apply(0, 1, 5, ADD_X6_X5_X7, 0, 0); sample();
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, NOP, 0, 1); sample();
      check("busy_hold", 64'(flags_o[1]), 64'b00001);
    end
    apply(0, 0, 0, NOP, 0, 0); sample();
    check("busy_resume", 64'(flags_o[1]), 64'b00010);
    apply(0, 0, 0, NOP, 0, 0); sample();
    check("busy_done", 64'(flags_o[1]), 64'b11000);
    check("busy_stall_count", 64'(scnt_o[1]), cnt_exp(2));

    // Reset aborts a stall.
    do_reset();
    apply(0, 1, 5, ADD_X6_X5_X7, 0, 0); sample();
    apply(1, 0, 0, NOP, 0, 0); sample();
    check("reset_in_stall", 64'(flags_o[1]), 64'b00110);
    apply(0, 0, 0, NOP, 0, 0); sample();
    check("reset_after", 64'(flags_o[1]), 64'b11000);
    check("reset_after_stall_cnt", 64'(scnt_o[1]), cnt_exp(0));
    check("reset_after_flush_cnt", 64'(fcnt_o[1]), cnt_exp(0));

    // Randomized traffic checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      logic [6:0]  ops [9];
      logic [31:0] ins;
      ops = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
      ins        = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      apply($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), ins,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    apply(0, 0, 0, NOP, 0, 0);
    sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard controller for the 5-stage RV64 pipeline. It decides when the pipeline stalls, flushes or freezes.
- Drives the ID_flush input of the ID/EX registers (datapath, control, immediate, pc). Also drives PC write enable and IF/ID write/flush.
- Consumes the EX-stage outputs of ID/EX (MemRead, Rd, branch/jump resolution) plus the ID-stage instruction, so it closes the ID/EX loop from the other end.
- Small FSM handles multi-cycle load-use stalls.

Parameters:
- STALL_CYCLES, 1, load-use bubble cycles inserted per hazard; legal range 1..3.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- id_instru, input, 32, instruction currently in ID (IF/ID output).
- ex_MemRead, input, 1, MemRead of the instruction in EX (ID/EX output).
- ex_Rd, input, 5, Rd of the instruction in EX.
- ex_taken, input, 1, branch taken or jump in EX (Branch&zero | Jump).
- mem_busy, input, 1, data memory not ready; whole pipeline must freeze.
- pc_write, output, 1, PC load enable.
- IF_ID_write, output, 1, IF/ID register load enable.
- IF_flush, output, 1, IF/ID clear (bubble).
- ID_flush, output, 1, ID/EX clear (bubble); connects to the ID_flush of all ID/EX registers.
- pipe_hold, output, 1, freeze for ID/EX, EX/MEM and MEM/WB.
- stall_count, output, CNT_W, load-use bubble cycles.
- flush_count, output, CNT_W, branch flushes.

Behaviour:
- State: STATE in {RUN, STALL} plus a 2-bit remaining counter rem. All outputs are combinational from state and inputs; state updates on the clock edge.
- Decode of id_instru:
  - rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
  - uses_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - uses_rs2 = opcode in {0110011 R, 0100011 store, 1100011 branch}.
- lu_hit = ex_MemRead & (ex_Rd != 0) & ((uses_rs1 & ex_Rd == rs1) | (uses_rs2 & ex_Rd == rs2)).
- Priority: reset > mem_busy > ex_taken > load-use/STALL > normal.
- reset=1:
  - pc_write=0, IF_ID_write=0, IF_flush=1, ID_flush=1, pipe_hold=0.
  - Next state RUN, rem=0; counters cleared.
  - Reset mid-stall aborts the stall.
- mem_busy=1:
  - pc_write=0, IF_ID_write=0, IF_flush=0, ID_flush=0, pipe_hold=1.
  - State and rem held. No counter increments.
- ex_taken=1 (not busy):
  - pc_write=1, IF_ID_write=1, IF_flush=1, ID_flush=1, pipe_hold=0.
  - Next state RUN, rem=0. Any pending load-use stall is discarded, because the dependent instruction is killed.
  - flush_count+1.
- RUN & lu_hit:
  - pc_write=0, IF_ID_write=0, IF_flush=0, ID_flush=1.
  - If STALL_CYCLES=1, stay RUN; else go to STALL with rem=STALL_CYCLES-1.
  - stall_count+1.
- STALL:
  - Same outputs as RUN & lu_hit; lu_hit is ignored, since EX holds a bubble.
  - rem decrements each cycle; when rem reaches 1, next state is RUN.
  - stall_count+1 per cycle.
- RUN, no hazard: pc_write=1, IF_ID_write=1, IF_flush=0, ID_flush=0, pipe_hold=0.
- Boundary cases:
  - ex_Rd=0 never stalls.
  - A store whose rs2 matches ex_Rd stalls.
  - Back-to-back loads, each with a dependent consumer, each get their own stall.
- Total load-use penalty is exactly STALL_CYCLES cycles. Branch penalty is 2 instructions killed, 1 cycle of flush signals.

Optional Feature:
- HAZARD_PERF_EN defined: stall_count and flush_count are CNT_W-bit counters as described above.
  - They wrap modulo 2^CNT_W.
  - Cleared on reset.
  - Frozen while mem_busy=1.
- Macro undefined: both ports remain present but are tied to 0, and no counter flops are built.

Test Plan:
- Load-use stall: ex_MemRead=1, ex_Rd=5, id_instru=0x00728333 (add x6,x5,x7) -> one cycle with ID_flush=1, pc_write=0, IF_ID_write=0. Next cycle with ex_MemRead=0 -> normal (1,1,0,0); stall_count=1.
- No false stalls:
  - ex_Rd=0 with id_instru=0x00100093 (addi x1,x0,1) -> no stall.
  - ex_Rd=5 with id_instru=0x000282B7 (lui x5,0x28; rs1 field=5) -> no stall.
- Branch beats load-use: ex_taken=1 and lu_hit in the same cycle -> IF_flush=1, ID_flush=1, pc_write=1; flush_count=1, stall_count=0.
- STALL_CYCLES=2:
  - lu_hit -> exactly 2 cycles with ID_flush=1, pc_write=0; stall_count=2.
  - Repeat with ex_taken=1 in the 2nd cycle -> flush outputs that cycle, state returns to RUN.
- mem_busy=1 for 3 cycles during STALL (STALL_CYCLES=2) -> pipe_hold=1, ID_flush=0, rem held. After release, 1 remaining stall cycle, then normal.
- reset=1 asserted during STALL -> next cycle outputs are the reset values (IF_flush=1, ID_flush=1, pc_write=0). After deassert: RUN, counters=0.
